// File: rtl/mmv_to_mmb_bridge_if.sv
// Word/burst memory-mapped bus shared by both sides of the bridge.
// On the slave-side bus bcnt is unused (single-word transfers only).
interface mmv_to_mmb_bridge_if #(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 8,
    parameter int BWIDTH = 4
);
    logic [AWIDTH-1:0] addr;
    logic [BWIDTH-1:0] bcnt;
    logic              wreq;
    logic [DWIDTH-1:0] wdat;
    logic              rreq;
    logic [DWIDTH-1:0] rdat;
    logic              rval;
    logic              busy;

    modport master (
        output addr, bcnt, wreq, wdat, rreq,
        input  rdat, rval, busy
    );

    modport slave (
        input  addr, wreq, wdat, rreq,
        output rdat, rval, busy
    );
endinterface

// File: rtl/mmv_to_mmb_bridge.sv
// Single-word slave to burst master bridge: contiguous writes are gathered in a
// show-ahead FIFO and flushed as one burst; reads become 1-word bursts.
module mmv_to_mmb_bridge #(
    parameter int    AWIDTH  = 4,
    parameter int    DWIDTH  = 8,
    parameter int    BWIDTH  = 4,
    parameter string RAMTYPE = "AUTO"
) (
    input  logic                  clk,
    input  logic                  reset,
    mmv_to_mmb_bridge_if.slave    s_bus,
    mmv_to_mmb_bridge_if.master   m_bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] WBURST  = 2'd2;
    localparam logic [1:0] RREQ    = 2'd3;

    localparam int              DEPTH = 2 ** BWIDTH;
    localparam logic [BWIDTH-1:0] MAXB = '1;
    // Wide enough that start+cnt never wraps, so a burst cannot cross the top address.
    localparam int              SW    = ((AWIDTH > BWIDTH) ? AWIDTH : BWIDTH) + 1;

    logic [1:0]        state_q, state_d;
    logic [AWIDTH-1:0] start_q, start_d;
    logic [AWIDTH-1:0] raddr_q, raddr_d;
    logic [BWIDTH-1:0] cnt_q, cnt_d;
    logic [BWIDTH-1:0] beat_q, beat_d;
    logic [BWIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [DWIDTH-1:0] head;
    logic [SW-1:0]     next_addr;
    logic              append;
    logic              push, pop;
    logic              busy, wreq, rreq;

    assign next_addr = SW'(start_q) + SW'(cnt_q);
    assign append    = s_bus.wreq && (SW'(s_bus.addr) == next_addr) && (cnt_q != MAXB);

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        raddr_d = raddr_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        push    = 1'b0;
        pop     = 1'b0;
        busy    = 1'b1;
        wreq    = 1'b0;
        rreq    = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (s_bus.wreq) begin
                    push    = 1'b1;
                    start_d = s_bus.addr;
                    cnt_d   = BWIDTH'(1);
                    state_d = COLLECT;
                end else if (s_bus.rreq) begin
                    raddr_d = s_bus.addr;
                    state_d = RREQ;
                end
            end
            COLLECT: begin
                if (append) begin
                    busy  = 1'b0;
                    push  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    beat_d  = '0;
                    state_d = WBURST;
                end
            end
            WBURST: begin
                wreq = 1'b1;
                if (!m_bus.busy) begin
                    pop    = 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == cnt_q - 1'b1) begin
                        state_d = IDLE;
                    end
                end
            end
            RREQ: begin
                rreq = 1'b1;
                if (!m_bus.busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            beat_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        start_q <= start_d;
        raddr_q <= raddr_d;
    end

    // "LOGIC" keeps the buffer in flops; any other value is passed to the RAM inferencer.
    if (RAMTYPE == "LOGIC") begin : g_flops
        (* ramstyle = "logic" *) logic [DWIDTH-1:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (push) mem[wr_ptr_q] <= s_bus.wdat;
        end
        assign head = mem[rd_ptr_q];
    end else begin : g_ram
        (* ramstyle = RAMTYPE *) logic [DWIDTH-1:0] mem [DEPTH];
        always_ff @(posedge clk) begin
            if (push) mem[wr_ptr_q] <= s_bus.wdat;
        end
        assign head = mem[rd_ptr_q];
    end

    // Master outputs are zero outside the states that own them.
    assign m_bus.addr = (state_q == WBURST) ? start_q :
                        (state_q == RREQ)   ? raddr_q : '0;
    assign m_bus.bcnt = (state_q == WBURST) ? cnt_q :
                        (state_q == RREQ)   ? BWIDTH'(1) : '0;
    assign m_bus.wdat = (state_q == WBURST) ? head : '0;
    assign m_bus.wreq = wreq;
    assign m_bus.rreq = rreq;

    assign s_bus.busy = busy;
    assign s_bus.rdat = m_bus.rdat;
    assign s_bus.rval = m_bus.rval;

endmodule

// File: tb/tb_mmv_to_mmb_bridge.sv
// Bench for mmv_to_mmb_bridge: burst-grouping model, memory-backed master-side slave
// with fixed read delay, directed write/read/stall/reset scenarios.
module tb_mmv_to_mmb_bridge;
    localparam int AW = 4, DW = 8, BW = 4, RDDELAY = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mmv_to_mmb_bridge_if #(.AWIDTH(AW), .DWIDTH(DW), .BWIDTH(BW)) s_bus ();
    mmv_to_mmb_bridge_if #(.AWIDTH(AW), .DWIDTH(DW), .BWIDTH(BW)) m_bus ();

    mmv_to_mmb_bridge #(.AWIDTH(AW), .DWIDTH(DW), .BWIDTH(BW), .RAMTYPE("AUTO")) dut (
        .clk   (clk),
        .reset (reset),
        .s_bus (s_bus),
        .m_bus (m_bus)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Memory-backed burst slave on the master side.
    logic [7:0]         smem [16];
    logic [3:0]         wbeat;
    logic [RDDELAY-1:0] pv = '0;
    logic [7:0]         pd [RDDELAY];

    always @(posedge clk) begin
        pv <= {pv[RDDELAY-2:0], m_bus.rreq & ~m_bus.busy & ~reset};
        pd[0] <= smem[m_bus.addr];
        for (int i = 1; i < RDDELAY; i++) pd[i] <= pd[i-1];
        if (reset) begin
            wbeat <= '0;
        end else if (m_bus.wreq && !m_bus.busy) begin
            smem[4'(m_bus.addr + wbeat)] <= m_bus.wdat;
            wbeat <= (4'(wbeat + 4'd1) == m_bus.bcnt) ? 4'd0 : 4'(wbeat + 4'd1);
        end
    end
    assign m_bus.rval = pv[RDDELAY-1];
    assign m_bus.rdat = pd[RDDELAY-1];

    // Reference model: accepted writes grouped into bursts; a burst closes on the
    // first cycle without a contiguous accepted write or when it reaches 15 words.
    bit         acc_w = 0, acc_r = 0;
    logic [3:0] acc_addr;
    logic [7:0] acc_data;
    bit         open = 0;
    int         mstart, mn;
    logic [7:0] mmem [16];
    logic [7:0] open_data[$];
    int         exp_addr[$], exp_bcnt[$], exp_raddr[$];
    logic [7:0] exp_data[$], rd_exp[$];

    task automatic close_burst();
        exp_addr.push_back(mstart);
        exp_bcnt.push_back(mn);
        foreach (open_data[i]) exp_data.push_back(open_data[i]);
        open_data.delete();
        open = 0;
    endtask

    initial forever begin
        @(posedge clk);
        if (reset) begin
            open = 0;
            open_data.delete();
            exp_addr.delete();
            exp_bcnt.delete();
            exp_data.delete();
        end else begin
            if (acc_w) begin
                if (open && int'(acc_addr) == mstart + mn && mn < 15) begin
                    mn++;
                    open_data.push_back(acc_data);
                end else begin
                    if (open) close_burst();
                    open = 1;
                    mstart = int'(acc_addr);
                    mn = 1;
                    open_data.push_back(acc_data);
                end
                mmem[acc_addr] = acc_data;
            end else if (open) begin
                close_burst();
            end
            if (acc_r) begin
                rd_exp.push_back(mmem[acc_addr]);
                exp_raddr.push_back(int'(acc_addr));
            end
        end
    end

    // Compare process: master-side bursts, read issue and read return.
    bit         in_burst = 0, prev_stall = 0;
    int         beats, cur_addr, cur_bcnt, n_rval = 0;
    logic [7:0] prev_wdat, last_rdat;
    int         last_raddr = -1;
    int         obs_addr[$], obs_bcnt[$];
    logic [7:0] obs_data[$];

    initial forever begin
        @(negedge clk);
        if (reset) begin
            in_burst = 0;
            prev_stall = 0;
        end else begin
            chk("wreq_rreq_exclusive", m_bus.wreq & m_bus.rreq, 0);
            if (in_burst) chk("wreq_held_in_burst", m_bus.wreq, 1);
            if (m_bus.wreq) begin
                if (!in_burst) begin
                    in_burst = 1;
                    beats = 0;
                    cur_addr = int'(m_bus.addr);
                    cur_bcnt = int'(m_bus.bcnt);
                    chk("burst_expected", exp_addr.size() > 0, 1);
                    if (exp_addr.size() > 0) begin
                        chk("burst_addr", m_bus.addr, exp_addr.pop_front());
                        chk("burst_bcnt", m_bus.bcnt, exp_bcnt.pop_front());
                    end
                end else begin
                    chk("addr_stable", m_bus.addr, cur_addr);
                    chk("bcnt_stable", m_bus.bcnt, cur_bcnt);
                    if (prev_stall) chk("wdat_stable", m_bus.wdat, prev_wdat);
                end
                if (!m_bus.busy) begin
                    chk("beat_expected", exp_data.size() > 0, 1);
                    if (exp_data.size() > 0) chk("beat_data", m_bus.wdat, exp_data.pop_front());
                    obs_data.push_back(m_bus.wdat);
                    beats++;
                    if (beats == cur_bcnt) begin
                        in_burst = 0;
                        obs_addr.push_back(cur_addr);
                        obs_bcnt.push_back(cur_bcnt);
                    end
                end
                prev_stall = m_bus.busy;
                prev_wdat  = m_bus.wdat;
            end else begin
                prev_stall = 0;
            end
            if (m_bus.rreq) begin
                chk("read_after_writes", (exp_addr.size() == 0 && !in_burst && !open), 1);
                chk("rreq_bcnt", m_bus.bcnt, 1);
                if (!m_bus.busy) begin
                    chk("rreq_expected", exp_raddr.size() > 0, 1);
                    if (exp_raddr.size() > 0) chk("rreq_addr", m_bus.addr, exp_raddr.pop_front());
                    last_raddr = int'(m_bus.addr);
                end
            end
            if (s_bus.rval) begin
                chk("rval_expected", rd_exp.size() > 0, 1);
                if (rd_exp.size() > 0) chk("rdat", s_bus.rdat, rd_exp.pop_front());
                last_rdat = s_bus.rdat;
                n_rval++;
            end
        end
    end

    task automatic do_write(input logic [3:0] a, input logic [7:0] d, output bit stalled);
        bit got = 0;
        stalled = 0;
        s_bus.addr = a;
        s_bus.wdat = d;
        s_bus.wreq = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (!s_bus.busy) got = 1;
            else begin
                stalled = 1;
                @(posedge clk); #1;
            end
        end
        chk("write_accepted", got, 1);
        if (got) begin
            acc_w = 1; acc_addr = a; acc_data = d;
        end
        @(posedge clk); #1;
        acc_w = 0;
        s_bus.wreq = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a);
        bit got = 0;
        s_bus.addr = a;
        s_bus.rreq = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (!s_bus.busy) got = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("read_accepted", got, 1);
        if (got) begin
            acc_r = 1; acc_addr = a;
        end
        @(posedge clk); #1;
        acc_r = 0;
        s_bus.rreq = 1'b0;
    endtask

    task automatic wait_quiet();
        bit quiet = 0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 300 && !quiet; i++) begin
            @(negedge clk);
            quiet = !open && exp_addr.size() == 0 && !in_burst && !m_bus.wreq &&
                    !m_bus.rreq && rd_exp.size() == 0;
        end
        chk("bridge_quiet", quiet, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit st;
        int ba, bd, nr;
        logic [7:0] t1d [3];
        t1d = '{8'hA0, 8'hA1, 8'hA2};
        s_bus.addr = '0; s_bus.wdat = '0; s_bus.wreq = 0; s_bus.rreq = 0; s_bus.bcnt = 4'd1;
        m_bus.busy = 0;
        reset = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_wreq", m_bus.wreq, 0);
        chk("rst_m_rreq", m_bus.rreq, 0);
        chk("rst_s_busy", s_bus.busy, 0);
        chk("rst_m_addr", m_bus.addr, 0);
        chk("rst_m_bcnt", m_bus.bcnt, 0);
        chk("rst_m_wdat", m_bus.wdat, 0);
        reset = 0;
        @(posedge clk); #1;

        // Three contiguous writes form one burst.
        ba = obs_addr.size(); bd = obs_data.size();
        do_write(4'h2, 8'hA0, st);
        do_write(4'h3, 8'hA1, st);
        do_write(4'h4, 8'hA2, st);
        wait_quiet();
        chk("t1_nbursts", obs_addr.size() - ba, 1);
        chk("t1_addr", obs_addr[ba], 2);
        chk("t1_bcnt", obs_bcnt[ba], 3);
        for (int i = 0; i < 3; i++) chk("t1_beat", obs_data[bd+i], t1d[i]);

        // Discontiguous write stalls until the first burst drains.
        ba = obs_addr.size(); bd = obs_data.size();
        do_write(4'h5, 8'h11, st);
        chk("t2_first_not_stalled", st, 0);
        do_write(4'h9, 8'h22, st);
        chk("t2_second_stalled", st, 1);
        wait_quiet();
        chk("t2_nbursts", obs_addr.size() - ba, 2);
        chk("t2_addr0", obs_addr[ba], 5);
        chk("t2_bcnt0", obs_bcnt[ba], 1);
        chk("t2_data0", obs_data[bd], 8'h11);
        chk("t2_addr1", obs_addr[ba+1], 9);
        chk("t2_bcnt1", obs_bcnt[ba+1], 1);
        chk("t2_data1", obs_data[bd+1], 8'h22);

        // Sixteen contiguous writes split at the 15-word limit.
        ba = obs_addr.size(); bd = obs_data.size();
        for (int i = 0; i < 16; i++) do_write(4'(i), 8'(i), st);
        wait_quiet();
        chk("t3_nbursts", obs_addr.size() - ba, 2);
        chk("t3_addr0", obs_addr[ba], 0);
        chk("t3_bcnt0", obs_bcnt[ba], 15);
        chk("t3_addr1", obs_addr[ba+1], 15);
        chk("t3_bcnt1", obs_bcnt[ba+1], 1);
        for (int i = 0; i < 16; i++) chk("t3_beat", obs_data[bd+i], i);

        // Write then read of the same address: read follows the drained write.
        ba = obs_addr.size(); nr = n_rval;
        do_write(4'h3, 8'h5A, st);
        do_read(4'h3);
        wait_quiet();
        chk("t4_write_burst", obs_addr[ba], 3);
        chk("t4_raddr", last_raddr, 3);
        chk("t4_nrval", n_rval - nr, 1);
        chk("t4_rdat", last_rdat, 8'h5A);

        // Five-cycle master stall after the first beat.
        ba = obs_addr.size(); bd = obs_data.size();
        for (int i = 0; i < 4; i++) do_write(4'(8 + i), 8'(8'h30 + i), st);
        begin
            bit seen = 0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(negedge clk);
                seen = m_bus.wreq;
            end
            chk("t5_burst_started", seen, 1);
        end
        @(posedge clk); #1;
        m_bus.busy = 1;
        repeat (5) @(posedge clk);
        #1;
        m_bus.busy = 0;
        wait_quiet();
        chk("t5_nbursts", obs_addr.size() - ba, 1);
        chk("t5_addr", obs_addr[ba], 8);
        chk("t5_bcnt", obs_bcnt[ba], 4);
        chk("t5_nbeats", obs_data.size() - bd, 4);
        for (int i = 0; i < 4; i++) chk("t5_beat", obs_data[bd+i], 8'h30 + i);

        // Reset during a write burst.
        for (int i = 0; i < 6; i++) do_write(4'(1 + i), 8'(8'h40 + i), st);
        begin
            bit seen = 0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(negedge clk);
                seen = m_bus.wreq;
            end
            chk("t6_burst_started", seen, 1);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        chk("t6_wreq_dropped", m_bus.wreq, 0);
        chk("t6_s_busy_clear", s_bus.busy, 0);
        reset = 0;
        @(posedge clk); #1;
        chk("t6_still_idle", m_bus.wreq, 0);
        ba = obs_addr.size(); bd = obs_data.size();
        do_write(4'h7, 8'h77, st);
        wait_quiet();
        chk("t6_nbursts", obs_addr.size() - ba, 1);
        chk("t6_addr", obs_addr[ba], 7);
        chk("t6_bcnt", obs_bcnt[ba], 1);
        chk("t6_data", obs_data[bd], 8'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
